audio_fir: RTL and testbench

AUDIO_FIR -- requirements
Module: audio_fir

---
 rtl/audio_fir.sv | 137 +++++++++++++
 tb/tb_audio_fir.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_fir.sv
// Time-multiplexed audio FIR: one multiplier walks TAPS taps per sample, Q2.14 coefficients.
// Define AUDIO_FIR_SAT_EN to clamp the output to 16-bit range instead of wrapping.
module audio_fir #(
  parameter int TAPS  = 16,
  parameter int SHIFT = 14,
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [15:0]             in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [15:0]             out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [15:0]             coef_data,
  output logic                    busy
);

  localparam int AW = $clog2(TAPS);
  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                  state_r;
  logic signed [15:0]      x_r [TAPS];
  logic signed [15:0]      h_r [TAPS];
  logic signed [ACC_W-1:0] acc_r;
  logic [AW-1:0]           tap_r;
  logic [15:0]             out_data_r;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic                    busy_r;

  logic signed [15:0]      x_sel_s;
  logic signed [15:0]      h_sel_s;
  logic signed [31:0]      prod_s;
  logic signed [ACC_W-1:0] sum_s;

  // Scale the unshifted accumulator sum down to a 16-bit sample.
  function automatic logic [15:0] reduce_out(input logic signed [ACC_W-1:0] v);
`ifdef AUDIO_FIR_SAT_EN
    logic signed [ACC_W-1:0] s;
    logic [15:0]             r;
    s = v >>> SHIFT;
    if (s > ACC_W'(32'sd32767)) begin
      r = 16'h7FFF;
    end else if (s < ACC_W'(-32'sd32768)) begin
      r = 16'h8000;
    end else begin
      r = s[15:0];
    end
    return r;
`else
    return v[SHIFT+15:SHIFT];
`endif
  endfunction

  // The single shared multiplier, fed by the tap counter.
  assign x_sel_s = x_r[tap_r];
  assign h_sel_s = h_r[tap_r];
  assign prod_s  = 32'(x_sel_s) * 32'(h_sel_s);
  assign sum_s   = acc_r + ACC_W'(prod_s);

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

  // Control FSM, delay line, coefficient bank and accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      tap_r       <= '0;
      out_data_r  <= 16'h0000;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_r[i] <= 16'sh0000;
        h_r[i] <= 16'sh0000;
      end
      h_r[0] <= 16'sh4000;
    end else begin
      case (state_r)
        IDLE: begin
          // Coefficient write lands before the MAC pass of a sample accepted on the same edge.
          if (coef_we) begin
            h_r[coef_addr] <= coef_data;
          end
          if (in_valid) begin
            x_r[0] <= in_data;
            for (int i = 1; i < TAPS; i++) begin
              x_r[i] <= x_r[i-1];
            end
            acc_r      <= '0;
            tap_r      <= '0;
            state_r    <= MAC;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        MAC: begin
          acc_r <= sum_s;
          tap_r <= tap_r + 1'b1;
          if (tap_r == LAST_TAP) begin
            out_data_r  <= reduce_out(sum_s);
            out_valid_r <= 1'b1;
            state_r     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_fir.sv
// Self-checking bench for audio_fir: directed scenarios plus randomized samples/coefficients
// checked against a plain dot-product reference model.
module tb_audio_fir;
  localparam int TAPS  = 16;
  localparam int SHIFT = 14;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int mx [TAPS];
  int mh [TAPS];

  audio_fir #(.TAPS(TAPS), .SHIFT(SHIFT), .ACC_W(40)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) begin
      mx[k] = 0;
      mh[k] = 0;
    end
    mh[0] = 16384;
  endfunction

  function automatic void model_push(input logic [15:0] s);
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = int'($signed(s));
  endfunction

  // Reference: y = floor(sum x[k]*h[k] / 2^SHIFT), then reduced to 16 bits.
  function automatic logic [15:0] model_out();
    longint acc;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(mx[k]) * longint'(mh[k]);
    acc = acc >>> SHIFT;
`ifdef AUDIO_FIR_SAT_EN
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`endif
    return acc[15:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; coef_we = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    model_reset();
  endtask

  task automatic write_coef(input int a, input logic [15:0] d);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'(a); coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
    mh[a] = int'($signed(d));
  endtask

  // Offers one sample (optionally with a simultaneous coefficient write); returns at the next negedge.
  task automatic accept_sample(input logic [15:0] s, input logic we, input int a, input logic [15:0] d);
    @(negedge clk);
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    in_data = s; in_valid = 1'b1;
    coef_we = we; coef_addr = 4'(a); coef_data = d;
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0; in_data = 16'($urandom);
    if (we) mh[a] = int'($signed(d));
    model_push(s);
  endtask

  task automatic wait_out(input string tag, input int pre, output logic [15:0] got);
    int cnt;
    cnt = pre;
    while (out_valid !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_latency"}, 32'(cnt), 32'(TAPS + 1));
    got = out_data;
    chk({tag, "_data"}, {16'd0, out_data}, {16'd0, model_out()});
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_sample(input string tag, input logic [15:0] s, output logic [15:0] got);
    accept_sample(s, 1'b0, 0, 16'h0000);
    wait_out(tag, 1, got);
    release_out();
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] held;
    logic [15:0] exp33;
    int          seen;

    reset_n = 1'b0; in_data = 16'h0000; in_valid = 1'b0; out_ready = 1'b0;
    coef_we = 1'b0; coef_addr = 4'd0; coef_data = 16'h0000;
    model_reset();
    do_reset();

    // Unity pass-through with reset coefficients.
    run_sample("passthru", 16'h1234, got);
    chk("passthru_lit", {16'd0, got}, 32'h1234);

    // Impulse response through h[k] = k+1.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'(k + 1));
    for (int i = 0; i < TAPS; i++) begin
      run_sample("impulse", (i == 0) ? 16'h4000 : 16'h0000, got);
      chk("impulse_lit", {16'd0, got}, 32'(i + 1));
    end

    // Full-scale input and coefficients.
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'h7FFF);
    for (int i = 0; i < TAPS; i++) run_sample("fullscale", 16'h7FFF, got);
`ifdef AUDIO_FIR_SAT_EN
    exp33 = 16'h7FFF;
`else
    exp33 = 16'hFFC0;
`endif
    chk("fullscale_16th", {16'd0, got}, {16'd0, exp33});

    // Back-pressure: hold OUT for 10 cycles while in_valid pulses.
    accept_sample(16'h0321, 1'b0, 0, 16'h0000);
    wait_out("stall", 1, held);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", {16'd0, out_data}, {16'd0, held});
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_busy", {31'd0, busy}, 32'd1);
      in_valid = i[0];
      in_data = 16'($urandom);
    end
    in_valid = 1'b0;
    release_out();
    run_sample("after_stall", 16'h0abc, got);

    // Coefficient write while busy is dropped; the same write in IDLE takes effect.
    do_reset();
    accept_sample(16'h1234, 1'b0, 0, 16'h0000);
    repeat (3) @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'h0000;
    @(negedge clk);
    coef_we = 1'b0;
    wait_out("busy_we", 5, got);
    chk("busy_we_lit", {16'd0, got}, 32'h1234);
    release_out();
    write_coef(0, 16'h0000);
    run_sample("idle_we", 16'h0777, got);
    chk("idle_we_lit", {16'd0, got}, 32'h0000);

    // Reset in the middle of a MAC pass.
    do_reset();
    accept_sample(16'h5555, 1'b0, 0, 16'h0000);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_data", {16'd0, out_data}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    chk("midrst_no_output", 32'(seen), 32'd0);
    run_sample("midrst_next", 16'h1234, got);
    chk("midrst_next_lit", {16'd0, got}, 32'h1234);

    // Random coefficients and samples, some with coefficient writes on the accept edge.
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'($urandom));
    for (int i = 0; i < 24; i++) begin
      accept_sample(16'($urandom), ($urandom_range(0, 2) == 0), $urandom_range(0, TAPS - 1),
                    16'($urandom));
      wait_out("random", 1, held);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("random_hold", {16'd0, out_data}, {16'd0, held});
      end
      release_out();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
